// File: rtl/serial_bcd_add_ctrl_pkg.sv
// Shared constants, state encoding and digit helpers for the serial BCD adder.
package serial_bcd_add_ctrl_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] CORR_VAL = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADD   = 3'd1,
    ST_CHECK = 3'd2,
    ST_CORR  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic digit_gt_max(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/serial_bcd_add_ctrl_fa.sv
// Single-bit full adder; the whole BCD datapath is serialised through one instance.
module serial_bcd_add_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_bcd_add_ctrl.sv
// Bit-serial packed-BCD adder: one full adder, LSB first, with per-digit +6 correction
// performed serially through the same adder.
module serial_bcd_add_ctrl
  import serial_bcd_add_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      invalid
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state_r;
  logic [W-1:0]       a_sr_r;
  logic [W-1:0]       b_sr_r;
  logic [3:0]         dig_r;
  logic [3:0]         corr_sr_r;
  logic               carry_r;
  logic [1:0]         bit_idx_r;
  logic [IDX_W-1:0]   dig_idx_r;

  logic fa_a_s, fa_b_s, fa_s_s, fa_cout_s;
  logic in_invalid_s;
  logic last_digit_s;

  serial_bcd_add_ctrl_fa u_fa (
    .a    (fa_a_s),
    .b    (fa_b_s),
    .cin  (carry_r),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

  // During correction the adder sees the partial digit and the +6 constant instead of operands.
  always_comb begin
    fa_a_s = a_sr_r[0];
    fa_b_s = b_sr_r[0];
    if (state_r == ST_CORR) begin
      fa_a_s = dig_r[0];
      fa_b_s = corr_sr_r[0];
    end else begin
      fa_a_s = a_sr_r[0];
      fa_b_s = b_sr_r[0];
    end
  end

  // Flag any non-BCD digit on the operands presented with start.
  always_comb begin
    in_invalid_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      in_invalid_s = in_invalid_s
                   | digit_gt_max(a[i*DIGIT_W +: DIGIT_W])
                   | digit_gt_max(b[i*DIGIT_W +: DIGIT_W]);
    end
  end

  assign last_digit_s = (dig_idx_r == IDX_W'(DIGITS - 1));

  // Control FSM and datapath registers; every output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      a_sr_r    <= '0;
      b_sr_r    <= '0;
      dig_r     <= 4'd0;
      corr_sr_r <= 4'd0;
      carry_r   <= 1'b0;
      bit_idx_r <= 2'd0;
      dig_idx_r <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr_r    <= a;
            b_sr_r    <= b;
            carry_r   <= 1'b0;
            bit_idx_r <= 2'd0;
            dig_idx_r <= '0;
            invalid   <= in_invalid_s;
            busy      <= 1'b1;
            state_r   <= ST_ADD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADD: begin
          a_sr_r    <= {1'b0, a_sr_r[W-1:1]};
          b_sr_r    <= {1'b0, b_sr_r[W-1:1]};
          dig_r     <= {fa_s_s, dig_r[3:1]};
          carry_r   <= fa_cout_s;
          bit_idx_r <= bit_idx_r + 2'd1;
          if (bit_idx_r == 2'd3) begin
            state_r <= ST_CHECK;
          end else begin
            state_r <= ST_ADD;
          end
        end
        ST_CHECK: begin
          bit_idx_r <= 2'd0;
          carry_r   <= 1'b0;
          if (carry_r || digit_gt_max(dig_r)) begin
            corr_sr_r <= CORR_VAL;
            state_r   <= ST_CORR;
          end else begin
            sum[dig_idx_r*DIGIT_W +: DIGIT_W] <= dig_r;
            if (last_digit_s) begin
              state_r <= ST_DONE;
            end else begin
              dig_idx_r <= dig_idx_r + IDX_W'(1);
              state_r   <= ST_ADD;
            end
          end
        end
        ST_CORR: begin
          dig_r     <= {fa_s_s, dig_r[3:1]};
          corr_sr_r <= {1'b0, corr_sr_r[3:1]};
          bit_idx_r <= bit_idx_r + 2'd1;
          if (bit_idx_r == 2'd3) begin
            // Correction carry is dropped; a corrected digit always carries into the next.
            sum[dig_idx_r*DIGIT_W +: DIGIT_W] <= {fa_s_s, dig_r[3:1]};
            carry_r <= 1'b1;
            if (last_digit_s) begin
              state_r <= ST_DONE;
            end else begin
              dig_idx_r <= dig_idx_r + IDX_W'(1);
              state_r   <= ST_ADD;
            end
          end else begin
            carry_r <= fa_cout_s;
            state_r <= ST_CORR;
          end
        end
        ST_DONE: begin
          cout    <= carry_r;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bcd_add_ctrl.sv
// Self-checking bench: directed corner cases plus random operands against a
// digit-wise decimal reference model.
module tb_serial_bcd_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  int n_cmp = 0;
  int n_err = 0;

  serial_bcd_add_ctrl #(.DIGITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: per digit t = a + b + carry; t > 9 means add 6 and carry.
  task automatic model(input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] s, output logic c,
                       output logic inv, output int lat);
    int carry;
    int corr;
    int acc;
    carry = 0;
    corr  = 0;
    acc   = 0;
    inv   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int ad;
      int bd;
      int t;
      ad = (int'(av) >> (4 * i)) & 15;
      bd = (int'(bv) >> (4 * i)) & 15;
      if (ad > 9 || bd > 9) inv = 1'b1;
      t = ad + bd + carry;
      if (t > 9) begin
        acc   = acc | (((t + 6) & 15) << (4 * i));
        carry = 1;
        corr++;
      end else begin
        acc   = acc | (t << (4 * i));
        carry = 0;
      end
    end
    s   = acc[15:0];
    c   = (carry != 0);
    lat = 5 * 4 + 4 * corr + 1;
  endtask

  // Launch one operation and measure done latency from the start-sampling edge.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] exp_s, input logic exp_c, input logic exp_inv,
                       input int exp_lat, input int glitch_cyc);
    int n;
    bit seen;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    seen = 1'b0;
    n    = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == glitch_cyc) begin
        a     = 16'($urandom);
        b     = 16'($urandom);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        n    = k;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_sum"}, 32'(sum), 32'(exp_s));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_c));
    chk({tag, "_invalid"}, 32'(invalid), 32'(exp_inv));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] rs;
    logic        rc;
    logic        ri;
    int          rl;
    bit          saw_done;
    logic [15:0] ra;
    logic [15:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_invalid", 32'(invalid), 32'd0);

    do_op("plain", 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 21, 0);
    do_op("carry1", 16'h0009, 16'h0001, 16'h0010, 1'b0, 1'b0, 25, 0);
    do_op("all9", 16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 37, 0);
    do_op("ripple", 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 37, 0);
    do_op("invalid", 16'h00A0, 16'h0000, 16'h0100, 1'b0, 1'b1, 25, 0);
    do_op("ignore_start", 16'h2468, 16'h1357, 16'h3825, 1'b0, 1'b0, 29, 3);
    do_op("back2back", 16'h0505, 16'h0505, 16'h1010, 1'b0, 1'b0, 29, 0);

    // Abort: reset sampled at the tenth busy cycle.
    @(negedge clk);
    a     = 16'h9999;
    b     = 16'h9999;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_invalid", 32'(invalid), 32'd0);
    saw_done = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_quiet", 32'(saw_done), 32'd0);

    for (int r = 0; r < 24; r++) begin
      if (r % 6 == 5) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end else begin
        for (int d = 0; d < 4; d++) begin
          ra[d*4 +: 4] = 4'($urandom_range(9, 0));
          rb[d*4 +: 4] = 4'($urandom_range(9, 0));
        end
      end
      model(ra, rb, rs, rc, ri, rl);
      do_op("rand", ra, rb, rs, rc, ri, rl, 0);
    end

    @(posedge clk);
    #1;
    chk("final_done_low", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_bcd_add_ctrl.md
SERIAL_BCD_ADD_CTRL -- requirements
Module: serial_bcd_add_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of packed BCD digits per operand.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1: request to begin an addition, sampled only in IDLE.
REQ-005 SHALL have port a, input, 4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL have port b, input, 4*DIGITS: operand B, same packing as a.
REQ-007 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-008 SHALL have port done, output, 1: single-cycle pulse marking a valid result.
REQ-009 SHALL have port sum, output, 4*DIGITS: packed BCD result.
REQ-010 SHALL have port cout, output, 1: decimal carry out of the most significant digit.
REQ-011 SHALL have port invalid, output, 1: at least one latched input digit exceeded 9.

Function
REQ-012 SHALL compute sum/cout with exactly one 1-bit full adder (a, b, cin -> s, cout), used bit-serially, LSB first.
REQ-013 SHALL implement the states IDLE, ADD, CHECK, CORR and DONE.
REQ-014 IDLE: on start=1, SHALL latch a and b, clear the carry, set digit index 0 and bit index 0, and enter ADD; otherwise SHALL stay in IDLE.
REQ-015 ADD: each cycle SHALL feed A bit, B bit and the carry to the adder, shift s into the digit register and store the adder carry; after 4 cycles SHALL enter CHECK.
REQ-016 CHECK (1 cycle): if the 4-bit carry-out c4=1 or the digit value is greater than 9, SHALL enter CORR; otherwise SHALL write the digit to sum, set the digit carry to 0 and advance.
REQ-017 CORR: SHALL add 4'b0110 to the digit serially through the same adder over 4 cycles with cin=0, discard the correction carry, write the digit to sum, set the digit carry to 1 and advance.
REQ-018 "Advance" SHALL mean: pass the digit carry as cin to the next digit and enter ADD; after digit DIGITS-1, SHALL enter DONE.
REQ-019 DONE: SHALL drive cout with the final digit carry, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-020 SHALL take 5 cycles for an uncorrected digit and 9 for a corrected digit; done SHALL assert (5*DIGITS + 4*corrections + 1) cycles after the edge that samples start.
REQ-021 SHALL set invalid when start is accepted if any digit of a or b is greater than 9; the computation SHALL still complete using the raw bits.
REQ-022 SHALL ignore start while busy=1, with no effect on the operation in progress.
REQ-023 SHALL hold sum, cout and invalid stable from DONE until the next accepted start.
REQ-024 SHALL allow start in the cycle after DONE (IDLE) to be accepted, giving back-to-back operations.

Reset
REQ-025 When rst_n=0 at a clock edge, SHALL enter IDLE and clear busy, done, sum, cout, invalid, the carry and all indices.
REQ-026 A reset during any non-IDLE state SHALL abort the operation without a done pulse.

Structure
REQ-027 SHALL place the state encoding, DIGIT_W=4, BCD_MAX=9 and CORR_VAL=4'b0110 in a shared package/header.
REQ-028 SHALL instantiate the existing 1-bit full-adder module exactly once as its only sub-module.

Verification
REQ-029 Bench SHALL check: a=0x1234, b=0x4321 -> sum=0x5555, cout=0, invalid=0, done after 21 cycles.
REQ-030 Bench SHALL check: a=0x0009, b=0x0001 -> sum=0x0010, cout=0, done after 25 cycles.
REQ-031 Bench SHALL check: a=0x9999, b=0x9999 -> sum=0x9998, cout=1, done after 37 cycles; a=0x9999, b=0x0001 -> sum=0x0000, cout=1, done after 37 cycles.
REQ-032 Bench SHALL check: a=0x00A0, b=0x0000 -> invalid=1, with done still pulsing once.
REQ-033 Bench SHALL check: start re-asserted in cycle 3 of busy -> ignored and the first result unchanged; rst_n=0 at cycle 10 -> IDLE, outputs 0, no done.
REQ-034 Bench SHALL check: start asserted in the cycle after done -> second operation accepted, with correct result and latency.
